stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Stopwatch timebase that produces the 16-bit packed-BCD `value` word consumed by the 4-digit FND scan driver. It counts seconds and centiseconds (SS.cc, 00.00–59.99) from the board clock and is controlled by three push-button inputs: start/stop, lap and clear. Its output connects directly to the driver's `value` input, one nibble per digit, most significant digit first.

## Interface
- `TICK_DIV`, default 1250000: clock cycles per 10 ms centisecond tick at 125 MHz (8 ns). Legal range is 2 or more. Benches use 4.
- `clk` input, 1 bit: system clock. All flops are rising-edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `btn_start` input, 1 bit: start/stop request, asynchronous, already debounced, level-high.
- `btn_lap` input, 1 bit: lap freeze/release request, same properties as `btn_start`.
- `btn_clear` input, 1 bit: clear request, same properties as `btn_start`.
- `value` output, 16 bits: {sec_tens, sec_ones, cs_tens, cs_ones}. Each nibble is BCD 0–9; sec_tens is 0–5.
- `running` output, 1 bit: high in RUN.
- `lap_active` output, 1 bit: high while `value` is frozen.

## Operation
- Input conditioning, per button:
  - two-flop synchronizer, then a third flop.
  - `press = sync2 & ~sync3`, one cycle wide per rising edge.
  - A held button yields exactly one press.
- State machine states:
  - IDLE (reset state): counters are zero.
  - RUN.
  - PAUSE.
- Transitions:
  - IDLE + start → RUN.
  - RUN + start → PAUSE.
  - PAUSE + start → RUN.
  - PAUSE + clear → IDLE.
  - clear is ignored in RUN and in IDLE (IDLE is already cleared).
- Press priority in the same cycle is clear > start > lap. Lower-priority presses in that cycle are discarded, not queued.
- Prescaler `div_cnt`, width is clog2(TICK_DIV):
  - increments only in RUN.
  - When it equals TICK_DIV-1, it wraps to 0 and asserts `tick` for one cycle.
  - It holds in PAUSE, so the fractional tick is preserved across a pause.
  - It is zeroed on entering IDLE.
- BCD counter, advanced by `tick`:
  - cs_ones 9→0 carries into cs_tens.
  - cs_tens 9→0 carries into sec_ones.
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 wraps the whole count.
  - 59.99 + tick → 00.00. Counting continues and no flag is raised.
  - No nibble ever holds a value above 9, and sec_tens never exceeds 5.
- Lap behaviour:
  - RUN + lap with `lap_active`=0: the current live count is captured into `lap_reg` and `lap_active` goes to 1.
  - RUN + lap with `lap_active`=1: `lap_active` goes to 0.
  - PAUSE + lap: `lap_active` goes to 0.
  - IDLE + lap: ignored.
  - Entering IDLE clears `lap_active`.
- `value` is registered: it equals `lap_reg` when `lap_active`=1, otherwise the live count.
- The live count keeps advancing while lap is active.
- Reset values: every flop is 0, so `value`=16'h0000, `running`=0, `lap_active`=0, and the state is IDLE. Reset may be asserted mid-count and takes effect immediately without waiting for a clock.

## Timing
- Button press latency:
  - the button is first sampled high at rising edge N (sync1).
  - `press` is high during cycle N+2.
  - state, `running` and `lap_active` update at edge N+3.
- `value` after a tick: the tick is high in the cycle where `div_cnt`=TICK_DIV-1. The live count updates at the following edge. `value` reflects it one edge later, giving 2 cycles of latency from the tick cycle.
- Tick spacing: exactly TICK_DIV cycles of RUN time between consecutive ticks, with paused cycles excluded.
- On a start press in IDLE, the first tick occurs TICK_DIV cycles after `running` rises.
- Lap capture uses the live count at the press edge. Any tick in that same cycle lands in the live count only, not in `lap_reg`.
- Reset release is synchronous to the first rising edge after `reset_n` goes high. Presses during reset are lost.

## Test plan
- Reset during count: with TICK_DIV=4, start, run 60 cycles, pulse `reset_n` low between edges → `value`=0000 with no clock edge, `running`=0, and the count stays 0 after release.
- Basic count: start, then 4×123 RUN cycles → `value`=16'h0123, `running`=1. Ticks are exactly 4 cycles apart.
- Pause/resume fraction: run 4×5+2 cycles, stop, idle 100 cycles, restart → the next tick arrives 2 RUN cycles after resume and `value` advances 0005→0006. Clear while paused → `value`=0000, IDLE.
- Wrap: preload by running 5999 ticks → `value`=16'h5999. One more tick → 16'h0000, still RUN. No nibble is ever seen above 9.
- Lap: at 16'h0042 press lap → `value` stays 0042 for 50 ticks. Press lap again → `value` shows live 16'h0092, `lap_active`=0.
- Simultaneous and held buttons:
  - clear + start together in PAUSE → IDLE, counts zero.
  - start + lap together in RUN → PAUSE, `lap_active` unchanged.
  - `btn_start` held 1000 cycles → exactly one transition.
  - clear in RUN → ignored.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// SS.cc stopwatch timebase driving a 4-digit packed-BCD display word.
// Three debounced buttons (start/stop, lap, clear) are synchronized and edge-detected.
module stopwatch_bcd #(
    parameter int unsigned TICK_DIV = 1250000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] value,
    output logic        running,
    output logic        lap_active
);

    localparam int unsigned DivW = $clog2(TICK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    // Button vectors are packed {clear, lap, start}.
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] press_d, press_q;

    state_e state_q, state_d;

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]      cs_ones_q, cs_ones_d;
    logic [3:0]      cs_tens_q, cs_tens_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [15:0]     lap_reg_q, lap_reg_d;
    logic            lap_active_q, lap_active_d;
    logic [15:0]     value_q, value_d;

    logic [15:0] live;
    logic        tick;
    logic        do_start, do_lap, do_clear;
    logic        enter_idle;

    assign btn_raw = {btn_clear, btn_lap, btn_start};
    assign press_d = sync2_q & ~sync3_q;
    assign live    = {sec_tens_q, sec_ones_q, cs_tens_q, cs_ones_q};

    // Only the highest-priority press in a cycle is acted on; the rest are dropped.
    assign do_clear = press_q[2];
    assign do_start = press_q[0] & ~press_q[2];
    assign do_lap   = press_q[1] & ~press_q[0] & ~press_q[2];

    assign enter_idle = (state_q != StIdle) && (state_d == StIdle);
    assign tick       = (state_q == StRun) && (div_cnt_q == DivMax);

    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        lap_reg_d    = lap_reg_q;
        unique case (state_q)
            StIdle: begin
                if (do_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (do_start) begin
                    state_d = StPause;
                end else if (do_lap) begin
                    if (lap_active_q) begin
                        lap_active_d = 1'b0;
                    end else begin
                        // Capture pre-tick count; a coincident tick only lands in live.
                        lap_active_d = 1'b1;
                        lap_reg_d    = live;
                    end
                end
            end
            StPause: begin
                if (do_clear) begin
                    state_d      = StIdle;
                    lap_active_d = 1'b0;
                end else if (do_start) begin
                    state_d = StRun;
                end else if (do_lap) begin
                    lap_active_d = 1'b0;
                end
            end
            default: begin
                state_d      = StIdle;
                lap_active_d = 1'b0;
            end
        endcase
    end

    // Prescaler holds in PAUSE so a partial centisecond survives a stop/start.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (enter_idle) begin
            div_cnt_d = '0;
        end else if (state_q == StRun) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_comb begin
        cs_ones_d  = cs_ones_q;
        cs_tens_d  = cs_tens_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        if (enter_idle) begin
            cs_ones_d  = '0;
            cs_tens_d  = '0;
            sec_ones_d = '0;
            sec_tens_d = '0;
        end else if (tick) begin
            if (cs_ones_q == 4'd9) begin
                cs_ones_d = '0;
                if (cs_tens_q == 4'd9) begin
                    cs_tens_d = '0;
                    if (sec_ones_q == 4'd9) begin
                        sec_ones_d = '0;
                        sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
                    end else begin
                        sec_ones_d = sec_ones_q + 4'd1;
                    end
                end else begin
                    cs_tens_d = cs_tens_q + 4'd1;
                end
            end else begin
                cs_ones_d = cs_ones_q + 4'd1;
            end
        end
    end

    always_comb begin
        value_d = lap_active_q ? lap_reg_q : live;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            press_q      <= '0;
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            cs_ones_q    <= '0;
            cs_tens_q    <= '0;
            sec_ones_q   <= '0;
            sec_tens_q   <= '0;
            lap_reg_q    <= '0;
            lap_active_q <= 1'b0;
            value_q      <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            press_q      <= press_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            cs_ones_q    <= cs_ones_d;
            cs_tens_q    <= cs_tens_d;
            sec_ones_q   <= sec_ones_d;
            sec_tens_q   <= sec_tens_d;
            lap_reg_q    <= lap_reg_d;
            lap_active_q <= lap_active_d;
            value_q      <= value_d;
        end
    end

    assign value      = value_q;
    assign running    = (state_q == StRun);
    assign lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: a cycle model feeds a scoreboard queue,
// plus fixed-value checkpoints taken from the stopwatch's documented behaviour.
module tb_stopwatch_bcd;

    localparam int TD = 4;
    localparam int MIdle = 0;
    localparam int MRun = 1;
    localparam int MPause = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] value;
    logic        running;
    logic        lap_active;

    stopwatch_bcd #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .value      (value),
        .running    (running),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        run;
        logic        lap;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ecnt = 0;
    int   m_state, m_div, m_live, m_lap, m_lap_reg, m_val;
    int   p_start = -1, p_lap = -1, p_clear = -1;

    function automatic logic [15:0] to_bcd(input int cs);
        int s, c;
        s = cs / 100;
        c = cs % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_state = MIdle; m_div = 0; m_live = 0; m_lap = 0; m_lap_reg = 0; m_val = 0;
        p_start = -1; p_lap = -1; p_clear = -1;
        sb_q.delete();
    endtask

    // Advance the reference model across one rising edge (ecnt already incremented).
    task automatic model_edge();
        int live_pre;
        bit c, s, l;
        live_pre = m_live;
        m_val = (m_lap != 0) ? m_lap_reg : m_live;
        if (m_state == MRun) begin
            if (m_div == TD - 1) begin
                m_div = 0;
                m_live = (m_live + 1) % 6000;
            end else begin
                m_div++;
            end
        end
        c = (p_clear == ecnt);
        s = (p_start == ecnt);
        l = (p_lap == ecnt);
        if (c) begin
            if (m_state == MPause) begin
                m_state = MIdle; m_div = 0; m_live = 0; m_lap = 0;
            end
        end else if (s) begin
            m_state = (m_state == MRun) ? MPause : MRun;
        end else if (l) begin
            if (m_state == MRun) begin
                if (m_lap != 0) m_lap = 0;
                else begin
                    m_lap = 1;
                    m_lap_reg = live_pre;
                end
            end else if (m_state == MPause) begin
                m_lap = 0;
            end
        end
    endtask

    task automatic step();
        exp_t x;
        @(posedge clk);
        ecnt++;
        model_edge();
        x.val = to_bcd(m_val);
        x.run = (m_state == MRun);
        x.lap = (m_lap != 0);
        sb_q.push_back(x);
        #1;
    endtask

    // A rising level driven now is sampled at edge ecnt+1 and acts at edge ecnt+4.
    task automatic press(input bit s, input bit l, input bit c);
        if (s) begin btn_start = 1'b1; p_start = ecnt + 4; end
        if (l) begin btn_lap = 1'b1; p_lap = ecnt + 4; end
        if (c) begin btn_clear = 1'b1; p_clear = ecnt + 4; end
    endtask

    task automatic release_all();
        btn_start = 1'b0;
        btn_lap = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic do_reset();
        release_all();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (value !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got value=%h running=%b lap_active=%b, want 0000 0 0",
                     value, running, lap_active);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            if (i == 0) press(1, 0, 0);
            if (i == 5) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL reset_run edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (value !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got value=%h running=%b lap_active=%b, want 0000 0 0",
                     value, running, lap_active);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL reset_after edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
        end
    endtask

    task automatic test_basic_count();
        int c;
        bit want;
        do_reset();
        c = ecnt;
        for (int i = 0; i < 497; i++) begin
            if (i == 0) press(1, 0, 0);
            if (i == 5) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL basic_count edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
            if (ecnt == c + 3 || ecnt == c + 4) begin
                want = (ecnt == c + 4);
                n_checks++;
                if (running !== want) begin
                    n_fail++;
                    $display("FAIL start_latency edge %0d: got running=%b, want %b",
                             ecnt, running, want);
                end
            end
        end
        n_checks++;
        if (value !== 16'h0123 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_0123: got value=%h running=%b, want 0123 1", value, running);
        end
    endtask

    task automatic test_pause_resume();
        int c;
        do_reset();
        c = ecnt;
        for (int i = 0; i < 150; i++) begin
            if (i == 0 || i == 22 || i == 122 || i == 130) press(1, 0, 0);
            if (i == 140) press(0, 0, 1);
            if (i == 4 || i == 26 || i == 126 || i == 134 || i == 144) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL pause_resume edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
            if (ecnt == c + 125 || ecnt == c + 128) begin
                n_checks++;
                if (value !== 16'h0005) begin
                    n_fail++;
                    $display("FAIL pause_hold edge %0d: got value=%h, want 0005", ecnt, value);
                end
            end
            if (ecnt == c + 129) begin
                n_checks++;
                if (value !== 16'h0006 || running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pause_fraction: got value=%h running=%b, want 0006 1",
                             value, running);
                end
            end
        end
        n_checks++;
        if (value !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_paused: got %h %b %b, want 0000 0 0",
                     value, running, lap_active);
        end
    endtask

    task automatic test_wrap();
        int c;
        do_reset();
        c = ecnt;
        for (int i = 0; i < 24006; i++) begin
            if (i == 0) press(1, 0, 0);
            if (i == 5) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL wrap_run edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
            n_checks++;
            if (value[3:0] > 4'd9 || value[7:4] > 4'd9 || value[11:8] > 4'd9 ||
                value[15:12] > 4'd5) begin
                n_fail++;
                $display("FAIL nibble_range edge %0d: got value=%h, want valid BCD", ecnt, value);
            end
            if (ecnt == c + 24001) begin
                n_checks++;
                if (value !== 16'h5999) begin
                    n_fail++;
                    $display("FAIL wrap_5999: got value=%h, want 5999", value);
                end
            end
        end
        n_checks++;
        if (value !== 16'h0000 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_0000: got value=%h running=%b, want 0000 1", value, running);
        end
    endtask

    task automatic test_lap();
        int c;
        do_reset();
        c = ecnt;
        for (int i = 0; i < 376; i++) begin
            if (i == 0) press(1, 0, 0);
            if (i == 170 || i == 370) press(0, 1, 0);
            if (i == 5 || i == 174) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL lap_run edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
            if (ecnt >= c + 175 && ecnt <= c + 373) begin
                n_checks++;
                if (value !== 16'h0042 || lap_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lap_frozen edge %0d: got value=%h lap_active=%b, want 0042 1",
                             ecnt, value, lap_active);
                end
            end
        end
        n_checks++;
        if (value !== 16'h0092 || lap_active !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_release: got %h %b %b, want 0092 running=1 lap_active=0",
                     value, running, lap_active);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        do_reset();
        c = ecnt;
        for (int i = 0; i < 1061; i++) begin
            if (i == 0 || i == 40) press(1, 0, 0);
            if (i == 10) press(0, 1, 0);
            if (i == 20) press(1, 1, 0);
            if (i == 30) press(1, 0, 1);
            if (i == 1050) press(0, 0, 1);
            if (i == 4 || i == 14 || i == 24 || i == 34 || i == 1040 || i == 1054) release_all();
            step();
            e = sb_q.pop_front();
            n_checks++;
            if (value !== e.val || running !== e.run || lap_active !== e.lap) begin
                n_fail++;
                $display("FAIL simul_run edge %0d: got %h %b %b, want %h %b %b",
                         ecnt, value, running, lap_active, e.val, e.run, e.lap);
            end
            if (ecnt == c + 25) begin
                n_checks++;
                if (running !== 1'b0 || lap_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_lap_prio: got running=%b lap_active=%b, want 0 1",
                             running, lap_active);
                end
            end
            if (ecnt == c + 36) begin
                n_checks++;
                if (value !== 16'h0000 || running !== 1'b0 || lap_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_start_prio: got %h %b %b, want 0000 0 0",
                             value, running, lap_active);
                end
            end
            if (ecnt == c + 1045) begin
                n_checks++;
                if (value !== 16'h0250 || running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL held_start: got value=%h running=%b, want 0250 1",
                             value, running);
                end
            end
        end
        n_checks++;
        if (value !== 16'h0254 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_in_run: got value=%h running=%b, want 0254 1", value, running);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_wrap();
        test_lap();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
